// File: rtl/rr_arbiter_4ch.sv
// rr_arbiter_4ch: four-channel round-robin arbiter feeding one registered output beat.
// Optional RR_PACKET_LOCK_EN keeps the grant on one channel until its in_last beat is accepted.
module rr_arbiter_4ch #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] in_data_a,
    input  logic [WIDTH-1:0] in_data_b,
    input  logic [WIDTH-1:0] in_data_c,
    input  logic [WIDTH-1:0] in_data_d,
`ifdef RR_PACKET_LOCK_EN
    input  logic [3:0]       in_last,
`endif
    output logic [3:0]       in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       select
);

    localparam int unsigned NCH = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       last_grant_q, last_grant_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       sel_q, sel_d;
`ifdef RR_PACKET_LOCK_EN
    logic             locked_q, locked_d;
`endif

    logic             grant_any;
    logic [1:0]       grant_idx;
    logic [1:0]       cand;
    logic             can_load;
    logic             fire;
    logic [WIDTH-1:0] grant_data;

    // Rotating-priority search starting one past the last winner.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 2'd0;
        cand      = 2'd0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            cand = last_grant_q + 2'(k);
            if (!grant_any && in_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
`ifdef RR_PACKET_LOCK_EN
        // A locked packet owns the output even while its channel is idle.
        if (locked_q) begin
            grant_any = in_valid[last_grant_q];
            grant_idx = last_grant_q;
        end
`endif
    end

    always_comb begin
        grant_data = in_data_a;
        case (grant_idx)
            2'd0:    grant_data = in_data_a;
            2'd1:    grant_data = in_data_b;
            2'd2:    grant_data = in_data_c;
            default: grant_data = in_data_d;
        endcase
    end

    assign can_load = (state_q == EMPTY) || out_ready;
    assign fire     = can_load && grant_any;

    always_comb begin
        in_ready = 4'b0000;
        if (!reset && fire) begin
            in_ready = 4'(1) << grant_idx;
        end
    end

    // Next-state and payload update.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        sel_d        = sel_q;
`ifdef RR_PACKET_LOCK_EN
        locked_d     = locked_q;
`endif
        case (state_q)
            EMPTY: begin
                if (fire) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_ready && !grant_any) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (fire) begin
            data_d       = grant_data;
            sel_d        = grant_idx;
            last_grant_d = grant_idx;
`ifdef RR_PACKET_LOCK_EN
            locked_d     = !in_last[grant_idx];
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= EMPTY;
            last_grant_q <= 2'd3;
            data_q       <= WIDTH'(0);
            sel_q        <= 2'd0;
`ifdef RR_PACKET_LOCK_EN
            locked_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            sel_q        <= sel_d;
`ifdef RR_PACKET_LOCK_EN
            locked_q     <= locked_d;
`endif
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign select    = sel_q;

endmodule

// File: tb/tb_rr_arbiter_4ch.sv
// Self-checking bench for rr_arbiter_4ch: directed scenarios plus randomized traffic
// compared against a behavioural round-robin model.
module tb_rr_arbiter_4ch;

    logic        clk;
    logic        reset;
    logic [3:0]  in_valid;
    logic [31:0] dat [4];
`ifdef RR_PACKET_LOCK_EN
    logic [3:0]  in_last;
`endif
    logic [3:0]  in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  select;

    int n_checks;
    int n_fail;

    // Behavioural model state
    bit          m_valid;
    logic [31:0] m_data;
    int          m_sel;
    int          m_lg;
    bit          m_lock;

    rr_arbiter_4ch #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data_a (dat[0]),
        .in_data_b (dat[1]),
        .in_data_c (dat[2]),
        .in_data_d (dat[3]),
`ifdef RR_PACKET_LOCK_EN
        .in_last   (in_last),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .select    (select)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int m_grant();
`ifdef RR_PACKET_LOCK_EN
        if (m_lock) return in_valid[m_lg] ? m_lg : -1;
`endif
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_lg + k) % 4;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_ready();
        int g;
        g = m_grant();
        if (g >= 0 && (!m_valid || out_ready)) return 4'(1) << g;
        return 4'b0000;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_data  = 32'h0;
        m_sel   = 0;
        m_lg    = 3;
        m_lock  = 0;
    endtask

    task automatic model_edge();
        int g;
        bit can;
        g   = m_grant();
        can = !m_valid || out_ready;
        if (can && g >= 0) begin
            m_valid = 1;
            m_data  = dat[g];
            m_sel   = g;
            m_lg    = g;
`ifdef RR_PACKET_LOCK_EN
            m_lock  = !in_last[g];
`endif
        end else if (can) begin
            m_valid = 0;
        end
    endtask

    // Advance one clock: model sees pre-edge inputs, then land on the falling edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) dat[i] = 32'hA0A0_0000 + 32'(i);
`ifdef RR_PACKET_LOCK_EN
        in_last = 4'b1111;
`endif
        model_reset();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        n_checks++; if (select !== 2'd0) begin n_fail++; $display("FAIL reset_select got=%0d exp=0", select); end
        n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
    endtask

    task automatic test_fairness();
        for (int i = 0; i < 4; i++) dat[i] = $urandom;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++; if (in_ready !== (4'b0001 << (k % 4))) begin n_fail++; $display("FAIL fair_in_ready[%0d] got=%b exp=%b", k, in_ready, 4'b0001 << (k % 4)); end
            tick();
            n_checks++; if (out_valid !== 1'b1 || select !== 2'(k % 4)) begin n_fail++; $display("FAIL fair_select[%0d] got=%0d/%b exp=%0d/1", k, select, out_valid, k % 4); end
            n_checks++; if (out_data !== dat[k % 4]) begin n_fail++; $display("FAIL fair_data[%0d] got=%h exp=%h", k, out_data, dat[k % 4]); end
        end
    endtask

    task automatic test_single();
        in_valid = 4'b0100;
        dat[2]   = 32'hDEADBEEF;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL single_in_ready[%0d] got=%b exp=0100", k, in_ready); end
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || select !== 2'd2) begin
                n_fail++; $display("FAIL single_beat[%0d] got=%b/%h/%0d exp=1/deadbeef/2", k, out_valid, out_data, select);
            end
        end
    endtask

    task automatic test_stall();
        in_valid = 4'b0010;
        dat[1]   = 32'h0000_0055;
        tick();
        n_checks++; if (select !== 2'd1 || out_data !== 32'h55) begin n_fail++; $display("FAIL stall_load got=%0d/%h exp=1/55", select, out_data); end
        out_ready = 1'b0;
        in_valid  = 4'b0110;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_in_ready[%0d] got=%b exp=0000", k, in_ready); end
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h55 || select !== 2'd1) begin
                n_fail++; $display("FAIL stall_hold[%0d] got=%b/%h/%0d exp=1/55/1", k, out_valid, out_data, select);
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL stall_release_ready got=%b exp=0100", in_ready); end
        tick();
        n_checks++; if (select !== 2'd2 || out_data !== dat[2]) begin n_fail++; $display("FAIL stall_release_sel got=%0d exp=2", select); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int i = 0; i < 4; i++) dat[i] = 32'h1000_0000 + 32'(i);
        #2;
        n_checks++; if (out_valid !== 1'b1 || out_data === 32'h0) begin n_fail++; $display("FAIL midrst_pre got=%b/%h exp=1/nonzero", out_valid, out_data); end
        reset = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin n_fail++; $display("FAIL midrst_async got=%b/%h exp=0/0", out_valid, out_data); end
        n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=0000", in_ready); end
        @(negedge clk);
        model_reset();
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b1 || select !== 2'd0 || out_data !== dat[0]) begin
            n_fail++; $display("FAIL midrst_first got=%b/%0d/%h exp=1/0/%h", out_valid, select, out_data, dat[0]);
        end
    endtask

    task automatic test_wrap();
        in_valid = 4'b1001;
        tick();
        n_checks++; if (select !== 2'd3 || out_data !== dat[3]) begin n_fail++; $display("FAIL wrap_first got=%0d exp=3", select); end
        tick();
        n_checks++; if (select !== 2'd0 || out_data !== dat[0]) begin n_fail++; $display("FAIL wrap_second got=%0d exp=0", select); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            in_valid  = 4'($urandom);
            out_ready = ($urandom % 4) != 0;
            for (int i = 0; i < 4; i++) dat[i] = $urandom;
`ifdef RR_PACKET_LOCK_EN
            in_last = 4'($urandom);
`endif
            #1;
            n_checks++; if (in_ready !== m_ready()) begin n_fail++; $display("FAIL rand_in_ready[%0d] got=%b exp=%b", k, in_ready, m_ready()); end
            tick();
            n_checks++; if (out_valid !== m_valid || out_data !== m_data || select !== 2'(m_sel)) begin
                n_fail++; $display("FAIL rand_out[%0d] got=%b/%h/%0d exp=%b/%h/%0d", k, out_valid, out_data, select, m_valid, m_data, m_sel);
            end
        end
    endtask

`ifdef RR_PACKET_LOCK_EN
    task automatic test_lock();
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        reset     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'b0010;
        in_last   = 4'b0000;
        tick();
        n_checks++; if (select !== 2'd1) begin n_fail++; $display("FAIL lock_beat0 got=%0d exp=1", select); end
        in_valid = 4'b0101;
        #1;
        n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL lock_idle_ready got=%b exp=0000", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lock_idle_drain got=%b exp=0", out_valid); end
        in_valid = 4'b0111;
        tick();
        n_checks++; if (select !== 2'd1) begin n_fail++; $display("FAIL lock_beat1 got=%0d exp=1", select); end
        in_last = 4'b0010;
        tick();
        n_checks++; if (select !== 2'd1) begin n_fail++; $display("FAIL lock_beat2 got=%0d exp=1", select); end
        in_last = 4'b0000;
        tick();
        n_checks++; if (select !== 2'd2) begin n_fail++; $display("FAIL lock_release got=%0d exp=2", select); end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_fairness();
        test_single();
        test_stall();
        test_reset_mid();
        test_wrap();
        test_random();
`ifdef RR_PACKET_LOCK_EN
        test_lock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_4ch.md
Name: rr_arbiter_4ch

Overview:
- Four-channel round-robin arbiter with valid/ready handshakes.
- Sits directly upstream of the 32-bit 4:1 mux stage.
- Picks one of four requesting source channels per beat and drives the registered 2-bit select index.
- Forwards the winning channel's data word into a single registered output stream.
- The registered select lets the downstream mux and the output word stay aligned on the same cycle.

Parameters:
- WIDTH, 32, data word width of every channel and of the output.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  4  per-channel request; bit i belongs to channel i (0=a, 1=b, 2=c, 3=d).
- in_data_a  input  WIDTH  channel 0 data.
- in_data_b  input  WIDTH  channel 1 data.
- in_data_c  input  WIDTH  channel 2 data.
- in_data_d  input  WIDTH  channel 3 data.
- in_ready  output  4  per-channel accept, at most one bit high; combinational.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accepts beat.
- out_data  output  WIDTH  registered winning word.
- select  output  2  registered index of the channel that produced out_data.

Behaviour:
- Reset, asynchronous, active-high, takes effect immediately and at any time, including mid-transfer:
  - out_valid=0, out_data=0, select=2'd0, in_ready=4'b0000.
  - Priority pointer last_grant=2'd3, so channel 0 has first priority.
  - Any held beat is discarded.
- Output register space:
  - can_load = !out_valid || out_ready.
- Grant, combinational:
  - Search in_valid starting at (last_grant+1) mod 4, wrapping 3->0.
  - The first set bit wins: grant_idx.
  - No valid bit set -> no grant.
- in_ready:
  - in_ready[grant_idx] = can_load when a grant exists.
  - All other bits are 0.
  - in_ready never depends on any in_valid bit other than through grant selection.
- Accept (fire) = can_load && a grant exists. On the next edge:
  - out_data <= channel[grant_idx] data.
  - select <= grant_idx.
  - out_valid <= 1.
  - last_grant <= grant_idx.
- Drain without refill: can_load && no grant -> out_valid <= 0. out_data and select keep their last values.
- Stall: out_valid && !out_ready -> out_data, select, out_valid and last_grant all hold.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 beat/cycle when out_ready is held high.
- Simultaneous drain and load: out_valid=1, out_ready=1 and a grant present -> the new beat loads in the same edge, no bubble.
- Fairness:
  - With all four valid continuously and out_ready=1, grant order is 0,1,2,3,0,...
  - A single requester wins every cycle.
- States:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
  - EMPTY->FULL on accept.
  - FULL->EMPTY on out_ready with no grant.
  - FULL->FULL on stall or on a simultaneous drain+load.

Optional Feature:
- Macro: RR_PACKET_LOCK_EN.
- Defined:
  - Adds input port in_last [3:0]; bit i marks the final beat of channel i's packet.
  - After channel i is accepted with in_last[i]=0, the arbiter locks onto i.
  - While locked, grant_idx=i whenever in_valid[i]=1. Other channels get in_ready=0 even when i is idle.
  - The lock releases on the accepted beat with in_last[i]=1, after which round-robin resumes from i+1.
  - Reset clears the lock.
- Undefined:
  - No in_last port.
  - Every beat re-arbitrates independently.

Test Plan:
1. Reset with out_ready=1 and in_valid=4'b1111, then deassert reset -> select sequence 0,1,2,3,0 on consecutive out_valid cycles; out_data tracks a/b/c/d.
2. Only in_valid[2]=1, data_c=32'hDEADBEEF, for 3 cycles -> out_valid=1 each cycle with out_data=32'hDEADBEEF, select=2; in_ready=4'b0100.
3. Load channel 1 (data_b=32'h0000_0055), then drop out_ready for 4 cycles -> out_data=32'h55 and select=1 stable; in_ready=4'b0000 throughout; on release the next grant is channel 2 if valid.
4. Assert reset mid-stall with out_valid=1 -> out_valid=0 and out_data=0 immediately, before the next edge; the next accept with all valid goes to channel 0.
5. in_valid=4'b1001 with last_grant=0 -> channel 3 wins first, then channel 0 (wrap-around check).
6. RR_PACKET_LOCK_EN: channel 1 sends 3 beats (in_last=0,0,1) while channels 0 and 2 stay valid -> three consecutive select=1 beats, then select=2.
